// File: rtl/uart_param.sv
// uart_param: parametrised full-duplex UART core.
// Runtime baud divisor, selectable parity, sticky parity/framing/overrun
// flags, one FIFO per direction (first-word-fall-through on the RX side).
// Optional build macro UART_LOOPBACK_EN adds a 'loopback' input that routes
// the TX shifter into the RX engine and parks the tx pin high.

module uart_param_fifo #(
   parameter int W  = 8,
   parameter int AW = 3
) (
   input  logic         clk_i,
   input  logic         reset_i,
   input  logic         wr_i,
   input  logic [W-1:0] w_data_i,
   input  logic         rd_i,
   output logic [W-1:0] r_data_o,
   output logic         empty_o,
   output logic         full_o
);
   localparam logic [AW:0]   DEPTH = (AW+1)'(2**AW);
   localparam logic [AW:0]   C_ONE = (AW+1)'(1);
   localparam logic [AW-1:0] P_ONE = AW'(1);

   logic [W-1:0]  mem_q [2**AW];
   logic [AW-1:0] wptr_q, rptr_q;
   logic [AW:0]   cnt_q, cnt_d;
   logic          do_wr, do_rd;

   assign empty_o  = (cnt_q == '0);
   assign full_o   = (cnt_q == DEPTH);
   assign do_rd    = rd_i & ~empty_o;
   // A full FIFO still accepts a write when the head is popped in the same cycle.
   assign do_wr    = wr_i & (~full_o | rd_i);
   assign r_data_o = empty_o ? '0 : mem_q[rptr_q];

   // Occupancy follows the effective push/pop pair.
   always_comb begin
      cnt_d = cnt_q;
      if (do_wr && !do_rd)      cnt_d = cnt_q + C_ONE;
      else if (!do_wr && do_rd) cnt_d = cnt_q - C_ONE;
   end

   // Storage array; data only, never reset.
   always_ff @(posedge clk_i) begin
      if (do_wr) mem_q[wptr_q] <= w_data_i;
   end

   // Pointers and count, wrapping modulo the depth.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         if (do_wr) wptr_q <= wptr_q + P_ONE;
         if (do_rd) rptr_q <= rptr_q + P_ONE;
         cnt_q <= cnt_d;
      end
   end
endmodule

module uart_param #(
   parameter int DBIT     = 8,
   parameter int SB_TICK  = 16,
   parameter int DVSR_BIT = 11,
   parameter int FIFO_W   = 3
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [DVSR_BIT-1:0] dvsr,
   input  logic [1:0]          parity_mode,
   input  logic                rx,
   output logic                tx,
   input  logic                wr_uart,
   input  logic [DBIT-1:0]     w_data,
   output logic                tx_full,
   input  logic                rd_uart,
   output logic [DBIT-1:0]     r_data,
   output logic                rx_empty,
   output logic                rx_full,
   output logic                parity_err,
   output logic                frame_err,
   output logic                overrun_err,
   input  logic                err_clr
`ifdef UART_LOOPBACK_EN
   ,input logic                loopback
`endif
);
   typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;

   localparam int S_W = 6;
   localparam logic [S_W-1:0]      S_MID  = S_W'(7);
   localparam logic [S_W-1:0]      S_BIT  = S_W'(15);
   localparam logic [S_W-1:0]      S_STOP = S_W'(SB_TICK - 1);
   localparam logic [S_W-1:0]      S_ONE  = S_W'(1);
   localparam logic [2:0]          N_LAST = 3'(DBIT - 1);
   localparam logic [2:0]          N_ONE  = 3'd1;
   localparam logic [DVSR_BIT-1:0] B_ONE  = DVSR_BIT'(1);

   logic [DVSR_BIT-1:0] bcnt_q, bcnt_d;
   logic                tick, par_en, par_odd, rx_src, rx_s;
   logic [1:0]          rx_sync_q;

   state_t              rx_st_q, tx_st_q;
   logic [S_W-1:0]      rx_s_q, tx_s_q;
   logic [2:0]          rx_n_q, tx_n_q;
   logic [DBIT-1:0]     rx_b_q, tx_b_q, tx_head;
   logic                rx_done_q, rx_perr_q, rx_ferr_q;
   logic                tx_par_q, tx_line_q, tx_empty, tx_go;
   logic                perr_q, ferr_q, oerr_q, ovr_set;

   assign par_en  = (parity_mode == 2'b01) || (parity_mode == 2'b10);
   assign par_odd = (parity_mode == 2'b10);

   // Baud tick: fires once count reaches dvsr-1 (or overshoots after dvsr shrank).
   always_comb begin
      tick   = (dvsr != '0) && (bcnt_q >= dvsr - B_ONE);
      bcnt_d = bcnt_q;
      if (dvsr != '0) bcnt_d = tick ? '0 : bcnt_q + B_ONE;
   end

   // Baud counter register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) bcnt_q <= '0;
      else       bcnt_q <= bcnt_d;
   end

`ifdef UART_LOOPBACK_EN
   assign rx_src = loopback ? tx_line_q : rx;
   assign tx     = tx_line_q | loopback;
`else
   assign rx_src = rx;
   assign tx     = tx_line_q;
`endif

   // Two-flop synchroniser on the asynchronous serial input.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) rx_sync_q <= 2'b11;
      else       rx_sync_q <= {rx_sync_q[0], rx_src};
   end
   assign rx_s = rx_sync_q[1];

   // RX engine: mid-bit sampling at 16 ticks per bit, raises done/error pulses.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_st_q   <= ST_IDLE;
         rx_s_q    <= '0;
         rx_n_q    <= '0;
         rx_b_q    <= '0;
         rx_done_q <= 1'b0;
         rx_perr_q <= 1'b0;
         rx_ferr_q <= 1'b0;
      end else begin
         rx_done_q <= 1'b0;
         rx_perr_q <= 1'b0;
         rx_ferr_q <= 1'b0;
         case (rx_st_q)
            ST_IDLE: if (!rx_s) begin
               rx_st_q <= ST_START;
               rx_s_q  <= '0;
            end
            ST_START: if (tick) begin
               if (rx_s_q == S_MID) begin
                  rx_st_q <= rx_s ? ST_IDLE : ST_DATA;
                  rx_s_q  <= '0;
                  rx_n_q  <= '0;
               end else rx_s_q <= rx_s_q + S_ONE;
            end
            ST_DATA: if (tick) begin
               if (rx_s_q == S_BIT) begin
                  rx_s_q <= '0;
                  rx_b_q <= {rx_s, rx_b_q[DBIT-1:1]};
                  if (rx_n_q == N_LAST) rx_st_q <= par_en ? ST_PARITY : ST_STOP;
                  else                  rx_n_q  <= rx_n_q + N_ONE;
               end else rx_s_q <= rx_s_q + S_ONE;
            end
            ST_PARITY: if (tick) begin
               if (rx_s_q == S_BIT) begin
                  rx_s_q    <= '0;
                  rx_perr_q <= (^rx_b_q) ^ rx_s ^ par_odd;
                  rx_st_q   <= ST_STOP;
               end else rx_s_q <= rx_s_q + S_ONE;
            end
            ST_STOP: if (tick) begin
               if (rx_s_q == S_BIT && !rx_s) rx_ferr_q <= 1'b1;
               if (rx_s_q == S_STOP) begin
                  rx_st_q   <= ST_IDLE;
                  rx_done_q <= 1'b1;
               end else rx_s_q <= rx_s_q + S_ONE;
            end
            default: rx_st_q <= ST_IDLE;
         endcase
      end
   end

   // A new TX frame starts from IDLE or straight out of the last stop tick.
   assign tx_go = tick && !tx_empty &&
                  ((tx_st_q == ST_IDLE) || (tx_st_q == ST_STOP && tx_s_q == S_STOP));

   // TX engine: shifts LSB first, tx line is registered with the state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tx_st_q   <= ST_IDLE;
         tx_s_q    <= '0;
         tx_n_q    <= '0;
         tx_b_q    <= '0;
         tx_par_q  <= 1'b0;
         tx_line_q <= 1'b1;
      end else if (tx_go) begin
         tx_st_q   <= ST_START;
         tx_s_q    <= '0;
         tx_b_q    <= tx_head;
         tx_par_q  <= (^tx_head) ^ par_odd;
         tx_line_q <= 1'b0;
      end else begin
         case (tx_st_q)
            ST_IDLE: tx_line_q <= 1'b1;
            ST_START: if (tick) begin
               if (tx_s_q == S_BIT) begin
                  tx_s_q    <= '0;
                  tx_n_q    <= '0;
                  tx_st_q   <= ST_DATA;
                  tx_line_q <= tx_b_q[0];
               end else tx_s_q <= tx_s_q + S_ONE;
            end
            ST_DATA: if (tick) begin
               if (tx_s_q == S_BIT) begin
                  tx_s_q <= '0;
                  tx_b_q <= tx_b_q >> 1;
                  if (tx_n_q == N_LAST) begin
                     tx_st_q   <= par_en ? ST_PARITY : ST_STOP;
                     tx_line_q <= par_en ? tx_par_q : 1'b1;
                  end else begin
                     tx_n_q    <= tx_n_q + N_ONE;
                     tx_line_q <= tx_b_q[1];
                  end
               end else tx_s_q <= tx_s_q + S_ONE;
            end
            ST_PARITY: if (tick) begin
               if (tx_s_q == S_BIT) begin
                  tx_s_q    <= '0;
                  tx_st_q   <= ST_STOP;
                  tx_line_q <= 1'b1;
               end else tx_s_q <= tx_s_q + S_ONE;
            end
            ST_STOP: if (tick) begin
               if (tx_s_q == S_STOP) tx_st_q <= ST_IDLE;
               else                  tx_s_q  <= tx_s_q + S_ONE;
            end
            default: tx_st_q <= ST_IDLE;
         endcase
      end
   end

   // Overrun: a finished word meets a full RX FIFO that is not being popped.
   assign ovr_set = rx_done_q & rx_full & ~rd_uart;

   // Sticky error flags; a new set wins over a simultaneous clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         perr_q <= 1'b0;
         ferr_q <= 1'b0;
         oerr_q <= 1'b0;
      end else begin
         perr_q <= (perr_q & ~err_clr) | rx_perr_q;
         ferr_q <= (ferr_q & ~err_clr) | rx_ferr_q;
         oerr_q <= (oerr_q & ~err_clr) | ovr_set;
      end
   end
   assign parity_err  = perr_q;
   assign frame_err   = ferr_q;
   assign overrun_err = oerr_q;

   uart_param_fifo #(.W(DBIT), .AW(FIFO_W)) u_rx_fifo (
      .clk_i(clk), .reset_i(reset), .wr_i(rx_done_q), .w_data_i(rx_b_q),
      .rd_i(rd_uart), .r_data_o(r_data), .empty_o(rx_empty), .full_o(rx_full)
   );

   uart_param_fifo #(.W(DBIT), .AW(FIFO_W)) u_tx_fifo (
      .clk_i(clk), .reset_i(reset), .wr_i(wr_uart), .w_data_i(w_data),
      .rd_i(tx_go), .r_data_o(tx_head), .empty_o(tx_empty), .full_o(tx_full)
   );
endmodule

// File: tb/tb_uart_param.sv
// Bench for uart_param: 8 data bits, 1 stop bit, 4-word FIFOs, dvsr=4
// (64 clocks per serial bit). Frames are built and decoded from the line
// protocol directly; a queue holds the words the RX side should deliver.

module tb_uart_param;
   localparam int BITC = 64;

   logic        clk = 1'b0;
   logic        reset;
   logic [10:0] dvsr;
   logic [1:0]  parity_mode;
   logic        rx, tx, rx_bit, loop_sel;
   logic        wr_uart, rd_uart, err_clr;
   logic [7:0]  w_data, r_data;
   logic        tx_full, rx_empty, rx_full;
   logic        parity_err, frame_err, overrun_err;
`ifdef UART_LOOPBACK_EN
   logic        loopback = 1'b0;
`endif

   int checks = 0;
   int fails  = 0;
   logic [7:0] rxq[$];

   always #5 clk = ~clk;
   assign rx = loop_sel ? tx : rx_bit;

   uart_param #(.DBIT(8), .SB_TICK(16), .DVSR_BIT(11), .FIFO_W(2)) dut (
      .clk(clk), .reset(reset), .dvsr(dvsr), .parity_mode(parity_mode),
      .rx(rx), .tx(tx), .wr_uart(wr_uart), .w_data(w_data), .tx_full(tx_full),
      .rd_uart(rd_uart), .r_data(r_data), .rx_empty(rx_empty), .rx_full(rx_full),
      .parity_err(parity_err), .frame_err(frame_err), .overrun_err(overrun_err),
      .err_clr(err_clr)
`ifdef UART_LOOPBACK_EN
      , .loopback(loopback)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] flags();
      return {29'd0, overrun_err, frame_err, parity_err};
   endfunction

   function automatic bit par_on(input logic [1:0] pm);
      return (pm == 2'b01) || (pm == 2'b10);
   endfunction

   // Parity bit a correct transmitter puts on the line.
   function automatic logic ref_par(input logic [7:0] d, input logic [1:0] pm);
      int ones = $countones(d);
      return (pm == 2'b10) ? ((ones % 2) == 0) : ((ones % 2) == 1);
   endfunction

   task automatic clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic write_word(input logic [7:0] d);
      @(negedge clk); w_data = d; wr_uart = 1'b1;
      @(negedge clk); wr_uart = 1'b0;
   endtask

   task automatic pop();
      @(negedge clk); rd_uart = 1'b1;
      @(negedge clk); rd_uart = 1'b0;
   endtask

   task automatic clear_err();
      @(negedge clk); err_clr = 1'b1;
      @(negedge clk); err_clr = 1'b0;
   endtask

   // Drive one frame on rx; a bad stop bit is low only through its middle.
   task automatic send_frame(input logic [7:0] d, input logic [1:0] pm,
                             input bit bad_par, input bit bad_stop);
      @(negedge clk);
      rx_bit = 1'b0; clks(BITC);
      for (int i = 0; i < 8; i++) begin rx_bit = d[i]; clks(BITC); end
      if (par_on(pm)) begin rx_bit = ref_par(d, pm) ^ bad_par; clks(BITC); end
      if (bad_stop) begin
         rx_bit = 1'b0; clks(40);
         rx_bit = 1'b1; clks(BITC - 40);
      end else begin
         rx_bit = 1'b1; clks(BITC);
      end
      clks(BITC);
   endtask

   // Decode one frame from the tx pin, sampling at mid-bit.
   task automatic get_tx_frame(input bit penb, output logic [7:0] d,
                               output logic p, output logic stp);
      int n = 0;
      d = '0; p = 1'b0; stp = 1'b0;
      while (tx !== 1'b0 && n < 3000) begin @(negedge clk); n++; end
      if (tx !== 1'b0) begin
         chk("tx_start_timeout", 32'd0, 32'd1);
         return;
      end
      clks(BITC / 2);
      chk("tx_startbit", {31'd0, tx}, 32'd0);
      for (int i = 0; i < 8; i++) begin clks(BITC); d[i] = tx; end
      if (penb) begin clks(BITC); p = tx; end
      clks(BITC); stp = tx;
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] d, exp_d;
      logic       p, stp;
      logic [1:0] pm;
      bit         bp, bs;
      int         zeros;

      reset = 1'b1; dvsr = 11'd4; parity_mode = 2'b00; rx_bit = 1'b1; loop_sel = 1'b0;
      wr_uart = 1'b0; rd_uart = 1'b0; err_clr = 1'b0; w_data = '0;
      clks(3);
      chk("rst_tx", {31'd0, tx}, 32'd1);
      chk("rst_rx_empty", {31'd0, rx_empty}, 32'd1);
      chk("rst_tx_full", {31'd0, tx_full}, 32'd0);
      chk("rst_rx_full", {31'd0, rx_full}, 32'd0);
      chk("rst_r_data", {24'd0, r_data}, 32'd0);
      chk("rst_flags", flags(), 32'd0);
      reset = 1'b0;
      clks(5);

      // tx wired back to rx
      loop_sel = 1'b1;
      write_word(8'hA5);
      clks(800);
      chk("loop_rx_empty", {31'd0, rx_empty}, 32'd0);
      chk("loop_r_data", {24'd0, r_data}, 32'hA5);
      chk("loop_flags", flags(), 32'd0);
      pop();
      chk("loop_drained", {31'd0, rx_empty}, 32'd1);
      loop_sel = 1'b0;
      clks(100);

      // even parity: transmitted parity bit and a received bad parity bit
      parity_mode = 2'b01;
      write_word(8'h07);
      get_tx_frame(1'b1, d, p, stp);
      chk("par_tx_data", {24'd0, d}, 32'h07);
      chk("par_tx_bit", {31'd0, p}, 32'd1);
      chk("par_tx_stop", {31'd0, stp}, 32'd1);
      clks(100);
      send_frame(8'h07, 2'b01, 1'b1, 1'b0);
      chk("par_err_flags", flags(), 32'd1);
      chk("par_err_data", {24'd0, r_data}, 32'h07);
      pop();
      clear_err();
      chk("par_err_clr", flags(), 32'd0);

      // framing error, then a clean frame
      parity_mode = 2'b00;
      send_frame(8'h3C, 2'b00, 1'b0, 1'b1);
      chk("frm_err_flags", flags(), 32'd2);
      chk("frm_err_data", {24'd0, r_data}, 32'h3C);
      pop();
      chk("frm_no_extra", {31'd0, rx_empty}, 32'd1);
      clear_err();
      send_frame(8'h5A, 2'b00, 1'b0, 1'b0);
      chk("frm_next_data", {24'd0, r_data}, 32'h5A);
      chk("frm_next_flags", flags(), 32'd0);
      pop();

      // start-bit glitch of 3 ticks
      @(negedge clk); rx_bit = 1'b0; clks(12); rx_bit = 1'b1;
      clks(200);
      chk("glitch_empty", {31'd0, rx_empty}, 32'd1);
      send_frame(8'hC3, 2'b00, 1'b0, 1'b0);
      chk("glitch_after", {24'd0, r_data}, 32'hC3);
      pop();

      // overrun on a 4-deep FIFO
      for (int i = 1; i <= 5; i++) begin
         send_frame(8'(i), 2'b00, 1'b0, 1'b0);
         if (i <= 4) rxq.push_back(8'(i));
      end
      chk("ovr_full", {31'd0, rx_full}, 32'd1);
      chk("ovr_flags", flags(), 32'd4);
      while (rxq.size() > 0) begin
         exp_d = rxq.pop_front();
         chk("ovr_read", {24'd0, r_data}, {24'd0, exp_d});
         pop();
      end
      chk("ovr_drained", {31'd0, rx_empty}, 32'd1);
      clear_err();

      // dvsr=0 freezes the transmitter
      dvsr = 11'd0;
      write_word(8'h96);
      zeros = 0;
      for (int i = 0; i < 600; i++) begin @(negedge clk); if (tx == 1'b0) zeros++; end
      chk("freeze_tx_idle", 32'(zeros), 32'd0);
      dvsr = 11'd4;
      get_tx_frame(1'b0, d, p, stp);
      chk("freeze_resume", {24'd0, d}, 32'h96);
      clks(100);

      // randomized received frames
      for (int k = 0; k < 10; k++) begin
         d  = 8'($urandom);
         pm = 2'($urandom_range(0, 3));
         bp = ($urandom_range(0, 3) == 0);
         bs = ($urandom_range(0, 5) == 0);
         parity_mode = pm;
         rxq.push_back(d);
         send_frame(d, pm, bp, bs);
         exp_d = rxq.pop_front();
         chk("rand_rx_data", {24'd0, r_data}, {24'd0, exp_d});
         chk("rand_rx_flags", flags(), {30'd0, bs, bp & par_on(pm)});
         pop();
         chk("rand_rx_empty", {31'd0, rx_empty}, 32'd1);
         clear_err();
      end

      // randomized transmitted bursts of two frames
      for (int k = 0; k < 4; k++) begin
         logic [7:0] w0, w1;
         w0 = 8'($urandom); w1 = 8'($urandom);
         pm = 2'($urandom_range(0, 3));
         parity_mode = pm;
         write_word(w0);
         write_word(w1);
         get_tx_frame(par_on(pm), d, p, stp);
         chk("rand_tx_data0", {24'd0, d}, {24'd0, w0});
         if (par_on(pm)) chk("rand_tx_par0", {31'd0, p}, {31'd0, ref_par(w0, pm)});
         chk("rand_tx_stop0", {31'd0, stp}, 32'd1);
         get_tx_frame(par_on(pm), d, p, stp);
         chk("rand_tx_data1", {24'd0, d}, {24'd0, w1});
         if (par_on(pm)) chk("rand_tx_par1", {31'd0, p}, {31'd0, ref_par(w1, pm)});
         clks(100);
      end

      // reset in the middle of a transmission
      parity_mode = 2'b00;
      write_word(8'hFF);
      write_word(8'hFF);
      write_word(8'hFF);
      begin
         int n = 0;
         while (tx !== 1'b0 && n < 200) begin @(negedge clk); n++; end
      end
      chk("rst_mid_started", {31'd0, tx}, 32'd0);
      clks(10);
      reset = 1'b1;
      #1;
      chk("rst_mid_tx", {31'd0, tx}, 32'd1);
      chk("rst_mid_tx_full", {31'd0, tx_full}, 32'd0);
      clks(2);
      reset = 1'b0;
      zeros = 0;
      for (int i = 0; i < 2000; i++) begin @(negedge clk); if (tx == 1'b0) zeros++; end
      chk("rst_mid_no_start", 32'(zeros), 32'd0);
      chk("rst_mid_rx_empty", {31'd0, rx_empty}, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end
endmodule

// File: doc/uart_param.md
Name: uart_param

Overview:
Parametrised full-duplex UART core, the successor to the fixed 8N1 UART top.
- Adds a runtime baud divisor, selectable parity, and sticky parity/framing/overrun error flags.
- Contains its own baud-tick generator, RX and TX engines, and one FIFO per direction.
- Sits between the board serial pins and the decoder/LCD datapath, which pops received words through rd_uart.

Parameters:
- DBIT, 8: data bits per frame, legal 5..8.
- SB_TICK, 16: oversample ticks for the stop period; 16/24/32 give 1/1.5/2 stop bits.
- DVSR_BIT, 11: width of the runtime divisor port.
- FIFO_W, 3: FIFO address bits; each FIFO holds 2^FIFO_W words.

Ports:
- clk  in  1  system clock; every register is on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- dvsr  in  DVSR_BIT  baud divisor; tick every dvsr clocks. 0 = ticks disabled.
- parity_mode  in  2  00 none, 01 even, 10 odd, 11 none.
- rx  in  1  serial input, idle high.
- tx  out  1  serial output, registered, idle high.
- wr_uart  in  1  push w_data into the TX FIFO.
- w_data  in  DBIT  TX write data.
- tx_full  out  1  TX FIFO full.
- rd_uart  in  1  pop the RX FIFO head.
- r_data  out  DBIT  RX FIFO head (first-word-fall-through).
- rx_empty  out  1  RX FIFO empty.
- rx_full  out  1  RX FIFO full.
- parity_err  out  1  sticky parity error.
- frame_err  out  1  sticky framing error.
- overrun_err  out  1  sticky overrun error.
- err_clr  in  1  clears all three sticky flags.

Behaviour:
- Reset values: tx=1; FIFOs empty (rx_empty=1, tx_full=0, rx_full=0); r_data=0; all error flags 0; both FSMs in IDLE; baud counter 0. Reset mid-frame aborts the frame; no partial word is stored or sent.
- Baud tick generator:
  - Counter runs 0..dvsr-1; a 1-clock tick is emitted when count>=dvsr-1, and count then returns to 0.
  - If dvsr shrinks below count, the next clock ticks and wraps.
  - dvsr=0: no ticks, both engines freeze in place.
- 16 ticks per data bit.
- RX FSM (states IDLE, START, DATA, PARITY, STOP):
  - IDLE→START when rx=0.
  - START: count 8 ticks (mid start bit). If rx=1 there, the start is a glitch: return to IDLE, nothing stored. Otherwise go to DATA.
  - DATA: sample every 16 ticks, LSB first, DBIT bits, then PARITY if parity is enabled, else STOP.
  - PARITY: sample 16 ticks later. A mismatch sets parity_err (even: XOR of data and parity bit must be 0; odd: must be 1).
  - STOP: sample rx 16 ticks after the last data/parity sample. rx=0 sets frame_err. Exit after SB_TICK ticks total, back to IDLE.
  - On exit: word written to the RX FIFO, even on parity or frame error.
  - If the RX FIFO is full, the word is dropped and overrun_err is set.
- TX FSM (states IDLE, START, DATA, PARITY, STOP):
  - IDLE with TX FIFO not empty and a tick: latch the head, pop the FIFO, go to START.
  - Each bit lasts 16 ticks, LSB first. The parity bit is sent only when parity is enabled. STOP holds tx=1 for SB_TICK ticks.
  - Frames go back-to-back while the FIFO is non-empty.
- FIFOs:
  - Write when full is ignored; read when empty is ignored.
  - Simultaneous read and write: both proceed, count unchanged; when empty, only the write takes effect.
  - Pointers wrap modulo 2^FIFO_W.
- Error flags: a set and err_clr in the same cycle leaves the flag set.
- parity_mode and dvsr changes mid-frame take effect on the next tick; the frame may corrupt, and the caller changes them only when idle.

Optional Feature:
UART_LOOPBACK_EN
- Defined: adds input port loopback (1 bit).
  - loopback=1: the RX engine takes the internal TX shifter output instead of rx, and the tx pin is held at 1.
  - loopback=0: normal operation.
- Undefined: no loopback port and no mux; rx always drives the RX engine.

Test Plan:
- dvsr=4, parity 00, tx wired to rx, write 0xA5 → after about 10 bits × 64 clocks, rx_empty=0, r_data=0xA5, all flags 0.
- parity 01, write 0x07 → transmitted parity bit is 1. Drive rx externally with 0x07 and parity bit 0 → parity_err=1, r_data=0x07 stored. Then pulse err_clr → parity_err=0.
- Drive a frame 0x3C with stop bit 0 → frame_err=1, 0x3C stored; the next valid frame is received normally.
- FIFO_W=2: receive 5 frames 0x01..0x05 without reading → rx_full=1, overrun_err=1; four reads return 0x01..0x04; 0x05 is lost.
- Hold rx low for 3 ticks, then high → no word stored, RX FSM back in IDLE.
- Assert reset mid-transmission of 0xFF → tx=1 immediately, TX FIFO empty; after release no further start bit appears.
